// File: rtl/alu_pipe_pkg.sv
// Shared opcode map and S1 payload type for the alu_pipe two-stage ALU.
package alu_pipe_pkg;

   localparam int MAX_W = 32;

   localparam logic [2:0] OP_CLR  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_PASS = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_SRL  = 3'b110;
   localparam logic [2:0] OP_SLL  = 3'b111;

   // Operands are stored LSB-aligned; bits at WIDTH and above stay zero.
   typedef struct packed {
      logic [MAX_W-1:0] a;
      logic [MAX_W-1:0] b;
      logic [2:0]       op;
   } s1_payload_t;

endpackage

// File: rtl/alu_pipe_addsub.sv
// WIDTH-bit ripple adder/subtractor; sub=1 computes a + ~b + 1.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             v
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] b_x;

   assign b_x  = b ^ {WIDTH{sub}};
   assign c[0] = sub;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      assign sum[i]  = a[i] ^ b_x[i] ^ c[i];
      assign c[i+1]  = (a[i] & b_x[i]) | (c[i] & (a[i] ^ b_x[i]));
   end

   assign c_out = c[WIDTH];
   assign v     = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with carry, overflow and sticky overflow flags.
// Build option: define ALU_PIPE_SAT_EN to saturate ADD/SUB results on signed overflow.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             overflow,
   output logic             carry,
   output logic             ovf_sticky,
   input  logic             clr_sticky
);

   localparam int             SHW   = $clog2(WIDTH) + 1;
   localparam logic [SHW-1:0] W_AMT = SHW'(WIDTH);

   s1_payload_t      s1_q, s1_d;
   logic             s1_valid_q, s1_valid_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d;
   logic             sticky_q, sticky_d;

   logic             s1_adv, in_fire, out_fire;
   logic [WIDTH-1:0] op_a, op_b, as_sum, calc_res;
   logic [SHW-1:0]   sh_amt;
   logic             as_sub, as_c, as_v, calc_v, calc_c;

   assign s1_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid_q && out_ready;

   assign op_a   = s1_q.a[WIDTH-1:0];
   assign op_b   = s1_q.b[WIDTH-1:0];
   assign sh_amt = op_b[SHW-1:0];
   assign as_sub = (s1_q.op == OP_SUB);

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a     (op_a),
      .b     (op_b),
      .sub   (as_sub),
      .sum   (as_sum),
      .c_out (as_c),
      .v     (as_v)
   );

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      calc_res = '0;
      calc_v   = 1'b0;
      calc_c   = 1'b0;
      case (s1_q.op)
         OP_AND:  calc_res = op_a & op_b;
         OP_OR:   calc_res = op_a | op_b;
         OP_PASS: calc_res = op_a;
         OP_ADD, OP_SUB: begin
            calc_res = as_sum;
            calc_v   = as_v;
            calc_c   = as_c;
`ifdef ALU_PIPE_SAT_EN
            // A wrapped sum with MSB set means the true result was too positive.
            if (as_v) calc_res = as_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                 : {1'b1, {(WIDTH-1){1'b0}}};
`endif
         end
         OP_SRL:  calc_res = (sh_amt >= W_AMT) ? '0 : (op_a >> sh_amt);
         OP_SLL:  calc_res = (sh_amt >= W_AMT) ? '0 : (op_a << sh_amt);
         default: calc_res = '0;
      endcase
   end

   always_comb begin
      s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
      s1_d       = s1_q;
      if (in_fire) begin
         s1_d                = '0;
         s1_d.a[WIDTH-1:0]   = src_a;
         s1_d.b[WIDTH-1:0]   = src_b;
         s1_d.op             = opcode;
      end

      s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
      res_d      = res_q;
      zero_d     = zero_q;
      ovf_d      = ovf_q;
      carry_d    = carry_q;
      if (s1_adv && s1_valid_q) begin
         res_d   = calc_res;
         zero_d  = (calc_res == '0);
         ovf_d   = calc_v;
         carry_d = calc_c;
      end

      // Set has priority over a coincident clear.
      sticky_d = (out_fire && ovf_q) || (sticky_q && !clr_sticky);
   end

   // NOTE: the S1 operand payload has no reset; s1_valid_q alone qualifies it.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         zero_q     <= 1'b1;
         ovf_q      <= 1'b0;
         carry_q    <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         res_q      <= res_d;
         zero_q     <= zero_d;
         ovf_q      <= ovf_d;
         carry_q    <= carry_d;
         sticky_q   <= sticky_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign alu_out    = res_q;
   assign zero       = zero_q;
   assign overflow   = ovf_q;
   assign carry      = carry_q;
   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   logic       clk, reset, in_valid, in_ready, out_valid, out_ready;
   logic [7:0] src_a, src_b, alu_out;
   logic [2:0] opcode;
   logic       zero, overflow, carry, ovf_sticky, clr_sticky;

   int checks = 0;
   int errors = 0;

`ifdef ALU_PIPE_SAT_EN
   localparam logic [7:0] EXP_7F_P_01 = 8'h7F;
   localparam logic [7:0] EXP_80_M_01 = 8'h80;
`else
   localparam logic [7:0] EXP_7F_P_01 = 8'h80;
   localparam logic [7:0] EXP_80_M_01 = 8'h7F;
`endif

   alu_pipe #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .src_a      (src_a),
      .src_b      (src_b),
      .opcode     (opcode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_out    (alu_out),
      .zero       (zero),
      .overflow   (overflow),
      .carry      (carry),
      .ovf_sticky (ovf_sticky),
      .clr_sticky (clr_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   // Issues one op with out_ready=1, returns its result, then lets it be consumed.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic clr, output logic [7:0] res, output logic z,
                        output logic v, output logic c);
      int n;
      in_valid = 1'b1; src_a = a; src_b = b; opcode = op; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL do_op_timeout got out_valid=%b exp 1", out_valid);
      end
      res = alu_out; z = zero; v = overflow; c = carry;
      clr_sticky = clr;
      @(posedge clk); #1;
      clr_sticky = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
      src_a = '0; src_b = '0; opcode = OP_CLR;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (alu_out !== 8'h00) begin errors++; $display("FAIL rst_alu_out got %h exp 00", alu_out); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL rst_zero got %b exp 1", zero); end
      checks++; if ({overflow, carry, ovf_sticky} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {overflow, carry, ovf_sticky}); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_logic;
      logic [7:0] r; logic z, v, c;
      do_op(8'hF0, 8'h3C, OP_AND, 1'b0, r, z, v, c);
      checks++; if (r !== 8'h30) begin errors++; $display("FAIL and_res got %h exp 30", r); end
      do_op(8'hF0, 8'h0F, OP_OR, 1'b0, r, z, v, c);
      checks++; if (r !== 8'hFF) begin errors++; $display("FAIL or_res got %h exp ff", r); end
      do_op(8'hA5, 8'h00, OP_PASS, 1'b0, r, z, v, c);
      checks++; if ({r, z} !== {8'hA5, 1'b0}) begin errors++; $display("FAIL pass_res got %h/%b exp a5/0", r, z); end
      do_op(8'hA5, 8'h5A, OP_CLR, 1'b0, r, z, v, c);
      checks++; if ({r, z, v, c} !== {8'h00, 3'b100}) begin errors++; $display("FAIL clr_res got %h/%b%b%b exp 00/100", r, z, v, c); end
   endtask

   task automatic test_add;
      logic [7:0] r; logic z, v, c;
      do_op(8'hFF, 8'h01, OP_ADD, 1'b0, r, z, v, c);
      checks++; if ({r, z, v, c} !== {8'h00, 3'b101}) begin errors++; $display("FAIL add_wrap got %h/%b%b%b exp 00/101", r, z, v, c); end
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL add_wrap_sticky got %b exp 0", ovf_sticky); end
      do_op(8'h7F, 8'h01, OP_ADD, 1'b0, r, z, v, c);
      checks++; if ({r, z, v, c} !== {EXP_7F_P_01, 3'b010}) begin errors++; $display("FAIL add_ovf got %h/%b%b%b exp %h/010", r, z, v, c, EXP_7F_P_01); end
      checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL add_ovf_sticky got %b exp 1", ovf_sticky); end
   endtask

   task automatic test_reset_midstream;
      out_ready = 1'b1; in_valid = 1'b1;
      src_a = 8'h01; src_b = 8'h01; opcode = OP_ADD;
      @(posedge clk); #1;
      src_a = 8'h55; opcode = OP_PASS;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checks++; if ({out_valid, alu_out, zero} !== {1'b0, 8'h00, 1'b1}) begin errors++; $display("FAIL mid_rst_out got %b/%h/%b exp 0/00/1", out_valid, alu_out, zero); end
      checks++; if ({overflow, ovf_sticky} !== 2'b00) begin errors++; $display("FAIL mid_rst_flags got %b exp 00", {overflow, ovf_sticky}); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1;
      src_a = 8'h0C; src_b = 8'h30; opcode = OP_OR;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1 got %b exp 0", out_valid); end
      @(posedge clk); #1;
      checks++; if ({out_valid, alu_out} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL lat_edge2 got %b/%h exp 1/3c", out_valid, alu_out); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_no_stale got %b exp 0", out_valid); end
   endtask

   task automatic test_sub;
      logic [7:0] r; logic z, v, c;
      do_op(8'h00, 8'h01, OP_SUB, 1'b0, r, z, v, c);
      checks++; if ({r, z, v, c} !== {8'hFF, 3'b000}) begin errors++; $display("FAIL sub_borrow got %h/%b%b%b exp ff/000", r, z, v, c); end
      do_op(8'h05, 8'h05, OP_SUB, 1'b0, r, z, v, c);
      checks++; if ({r, z, v, c} !== {8'h00, 3'b101}) begin errors++; $display("FAIL sub_equal got %h/%b%b%b exp 00/101", r, z, v, c); end
      do_op(8'h80, 8'h01, OP_SUB, 1'b0, r, z, v, c);
      checks++; if ({r, z, v, c} !== {EXP_80_M_01, 3'b011}) begin errors++; $display("FAIL sub_ovf got %h/%b%b%b exp %h/011", r, z, v, c, EXP_80_M_01); end
   endtask

   task automatic test_shift;
      logic [7:0] r; logic z, v, c;
      do_op(8'hF0, 8'h04, OP_SRL, 1'b0, r, z, v, c);
      checks++; if ({r, v, c} !== {8'h0F, 2'b00}) begin errors++; $display("FAIL srl_4 got %h/%b%b exp 0f/00", r, v, c); end
      do_op(8'h81, 8'h01, OP_SLL, 1'b0, r, z, v, c);
      checks++; if (r !== 8'h02) begin errors++; $display("FAIL sll_1 got %h exp 02", r); end
      do_op(8'hFF, 8'h09, OP_SRL, 1'b0, r, z, v, c);
      checks++; if ({r, z} !== {8'h00, 1'b1}) begin errors++; $display("FAIL srl_9 got %h/%b exp 00/1", r, z); end
      do_op(8'hFF, 8'h18, OP_SLL, 1'b0, r, z, v, c);
      checks++; if ({r, z} !== {8'h00, 1'b1}) begin errors++; $display("FAIL sll_18 got %h/%b exp 00/1", r, z); end
      do_op(8'h11, 8'h13, OP_SLL, 1'b0, r, z, v, c);
      checks++; if (r !== 8'h88) begin errors++; $display("FAIL sll_13 got %h exp 88", r); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] va [4] = '{8'h01, 8'h10, 8'h44, 8'h09};
      logic [7:0] vb [4] = '{8'h02, 8'h01, 8'h00, 8'h02};
      logic [2:0] vo [4] = '{OP_ADD, OP_OR, OP_PASS, OP_SUB};
      logic [7:0] ve [4] = '{8'h03, 8'h11, 8'h44, 8'h07};
      logic [7:0] got [$];
      int idx, cyc;
      logic fire_in;
      idx = 0; cyc = 0;
      while ((idx < 4 || got.size() < 4) && cyc < 40) begin
         in_valid  = (idx < 4);
         if (idx < 4) begin src_a = va[idx]; src_b = vb[idx]; opcode = vo[idx]; end
         out_ready = (cyc >= 4);
         @(negedge clk);
         fire_in = in_valid && in_ready;
         if (cyc == 2) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
            checks++; if ({out_valid, alu_out} !== {1'b1, ve[0]}) begin errors++; $display("FAIL bp_head got %b/%h exp 1/%h", out_valid, alu_out, ve[0]); end
         end
         if (cyc == 3) begin
            checks++; if (alu_out !== ve[0]) begin errors++; $display("FAIL bp_hold got %h exp %h", alu_out, ve[0]); end
         end
         if (out_valid && out_ready) got.push_back(alu_out);
         @(posedge clk); #1;
         if (fire_in) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) begin
            checks++; if (got[i] !== ve[i]) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", i, got[i], ve[i]); end
         end
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_sticky;
      logic [7:0] r; logic z, v, c;
      do_op(8'h7F, 8'h01, OP_ADD, 1'b0, r, z, v, c);
      checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set got %b exp 1", ovf_sticky); end
      do_op(8'h40, 8'h40, OP_ADD, 1'b1, r, z, v, c);
      checks++; if ({v, ovf_sticky} !== 2'b11) begin errors++; $display("FAIL sticky_set_wins got %b exp 11", {v, ovf_sticky}); end
      clr_sticky = 1'b1;
      @(posedge clk); #1;
      clr_sticky = 1'b0;
      checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr got %b exp 0", ovf_sticky); end
      in_valid = 1'b1; out_ready = 1'b0;
      src_a = 8'h7F; src_b = 8'h01; opcode = OP_ADD;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({out_valid, overflow, ovf_sticky} !== 3'b110) begin errors++; $display("FAIL sticky_held got %b exp 110", {out_valid, overflow, ovf_sticky}); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if ({out_valid, ovf_sticky} !== 2'b01) begin errors++; $display("FAIL sticky_accept got %b exp 01", {out_valid, ovf_sticky}); end
   endtask

   initial begin
      test_reset();
      test_logic();
      test_add();
      test_reset_midstream();
      test_sub();
      test_shift();
      test_back_to_back();
      test_sticky();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the team's 4-bit registered ALU. It keeps the same 3-bit opcode map, and generalises the datapath to WIDTH bits. It adds valid/ready handshakes on input and output, a carry flag, and a sticky overflow flag. It sits between an operand-issue stage and a result-writeback consumer, and tolerates backpressure without dropping or duplicating operations.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32
SHW, $clog2(WIDTH)+1, width of the shift-amount field taken from src_b LSBs (derived; do not override)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept this cycle
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B / shift amount
opcode  input  3  operation select
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
alu_out  output  WIDTH  result
zero  output  1  alu_out == 0
overflow  output  1  signed overflow (ADD/SUB only)
carry  output  1  carry-out / no-borrow (ADD/SUB only)
ovf_sticky  output  1  set by any accepted result with overflow=1
clr_sticky  input  1  synchronous clear of ovf_sticky

Behaviour:
- Reset asserted (reset=0, async): both stages invalid; out_valid=0, alu_out=0, zero=1, overflow=0, carry=0, ovf_sticky=0. In-flight operations are discarded. in_ready=1 from the first edge after deassertion.
- Two stages:
  - S1 registers {src_a, src_b, opcode}.
  - S2 computes and registers {alu_out, zero, overflow, carry}.
- Latency: the result appears with out_valid=1 two clk edges after in_valid&&in_ready was sampled.
- Handshake:
  - Transfer on valid&&ready.
  - out_valid stays high and S2 outputs hold stable until out_ready=1.
  - in_ready = !s1_valid || s1_adv; s1_adv = !s2_valid || out_ready. in_ready is combinational from out_ready; no other comb paths.
  - Full throughput: one op per cycle when out_ready is held at 1.
- Opcodes:
  - 000 CLR: result 0
  - 001 AND: a&b
  - 010 OR: a|b
  - 011 PASS: a
  - 100 ADD: a+b
  - 101 SUB: a-b, computed as a+~b+1
  - 110 SRL: logical a>>b[SHW-1:0]
  - 111 SLL: a<<b[SHW-1:0]
- Shift amount ≥ WIDTH: result 0. Bits of src_b above SHW-1 are ignored.
- carry:
  - ADD: carry-out of the MSB.
  - SUB: carry-out of a+~b+1, i.e. 1 = no borrow.
  - 0 for all other opcodes.
- overflow:
  - ADD/SUB: carry into MSB XOR carry out of MSB.
  - 0 for all other opcodes.
- zero: 1 iff alu_out==0, for every opcode.
- ovf_sticky: set on the cycle after out_valid&&out_ready&&overflow. Cleared on the cycle after clr_sticky=1. If set and clear coincide, set wins. Held results that have not been accepted do not set it.

Optional Feature:
- Macro ALU_PIPE_SAT_EN.
- Defined: ADD/SUB saturate to the signed range on overflow.
  - Positive overflow → 0x7F..F; negative overflow → 0x80..0.
  - overflow and carry still report the unsaturated condition.
  - zero reflects the saturated result.
- Undefined: ADD/SUB wrap modulo 2^WIDTH.

Decomposition:
- Package alu_pipe_pkg:
  - opcode localparams OP_CLR, OP_AND, OP_OR, OP_PASS, OP_ADD, OP_SUB, OP_SRL, OP_SLL (3'b000..3'b111)
  - a packed S1 payload struct typedef.
- One sub-module: alu_addsub. It is a parametrised WIDTH-bit ripple adder/subtractor: inputs a, b, sub; outputs sum, c_out, v. It is combinational and instantiated once in S2.

Test Plan:
- WIDTH=8, reset=0 mid-stream with two ops in flight → next cycle out_valid=0, alu_out=0x00, zero=1, overflow=0, ovf_sticky=0. After release, the first accepted op's result appears 2 edges later.
- ADD 0x7F+0x01 → alu_out=0x80, overflow=1, carry=0, zero=0; ovf_sticky=1 after accept. With ALU_PIPE_SAT_EN defined → alu_out=0x7F, overflow=1.
- SUB 0x00-0x01 → 0xFF, carry=0, overflow=0. SUB 0x05-0x05 → 0x00, zero=1, carry=1.
- SRL 0xF0 by 4 → 0x0F. SLL 0x81 by 1 → 0x02. SRL 0xFF by b=0x09 → 0x00, zero=1. SLL by b=0x18 → uses b[3:0]=8 → 0x00.
- Backpressure: stream 4 back-to-back ops with out_ready=0 for 3 cycles → in_ready drops after 2 accepted. alu_out holds the first result. On release, all 4 results emerge in order with no loss or duplication.
- ovf_sticky=1, then clr_sticky=1 on the same cycle as accept of an overflowing ADD → ovf_sticky stays 1. Later clr_sticky alone → 0.
